// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a multiplexed seven-segment bus, filters each
// {digit select, segment} combination for stability, decodes the captured
// patterns back to hex nibbles and hands complete frames out over valid/ready.
//
// state   | meaning
// COLLECT | gathering digits, frame_valid low
// PENDING | complete frame held on frame_data, frame_valid high
module seg_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [6:0]              seg_in,
   input  logic [NUM_DIGITS-1:0]   an_in,
   output logic [4*NUM_DIGITS-1:0] frame_data,
   output logic                    frame_valid,
   input  logic                    frame_ready,
   output logic                    bad_pat,
   output logic                    overrun
);

   localparam int SW = NUM_DIGITS + 7;
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int DW = 4 * NUM_DIGITS;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_PENDING = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [SW-1:0]         samp_q, samp_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [NUM_DIGITS-1:0] seen_q, seen_d;
   logic [DW-1:0]         digit_q, digit_d;
   logic [DW-1:0]         frame_q, frame_d;
   logic                  bad_q, bad_d;
   logic                  overrun_q, overrun_d;

   logic                  capture;
   logic                  an_onehot;
   logic                  cap_legal;
   logic [NUM_DIGITS-1:0] seen_nx;
   logic                  complete;
   logic [4:0]            dec;

   // Returns {legal, nibble}; blank and unknown patterns come back not legal.
   function automatic logic [4:0] seg_decode(input logic [6:0] p);
      logic [4:0] r;
      case (p)
         7'b1111110: r = 5'h10;
         7'b0110000: r = 5'h11;
         7'b1101101: r = 5'h12;
         7'b1111001: r = 5'h13;
         7'b0110011: r = 5'h14;
         7'b1011011: r = 5'h15;
         7'b1011111: r = 5'h16;
         7'b1110000: r = 5'h17;
         7'b1111111: r = 5'h18;
         7'b1110011: r = 5'h19;
         7'b1110111: r = 5'h1A;
         7'b0011111: r = 5'h1B;
         7'b1001110: r = 5'h1C;
         7'b0111101: r = 5'h1D;
         7'b1001111: r = 5'h1E;
         7'b1000111: r = 5'h1F;
         default:    r = 5'h00;
      endcase
      return r;
   endfunction

   // Stability filter: one capture per stable episode, on the STABLE_CYCLES+1'th identical sample.
   always_comb begin
      samp_d    = {an_in, seg_in};
      cnt_d     = cnt_q;
      capture   = 1'b0;
      an_onehot = (an_in != '0) && ((an_in & (an_in - NUM_DIGITS'(1))) == '0);
      if ({an_in, seg_in} != samp_q) begin
         cnt_d = '0;
      end else begin
         if (cnt_q < CW'(STABLE_CYCLES)) cnt_d = cnt_q + CW'(1);
         capture = (cnt_q == CW'(STABLE_CYCLES - 1)) && an_onehot;
      end
   end

   // Decode the captured pattern and apply it to the digit registers.
   always_comb begin
      dec       = seg_decode(seg_in);
      cap_legal = capture && dec[4];
      bad_d     = capture && !dec[4] && (seg_in != 7'b0000000);
      digit_d   = digit_q;
      seen_nx   = seen_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (cap_legal && an_in[i]) begin
            digit_d[4*i +: 4] = dec[3:0];
            seen_nx[i]        = 1'b1;
         end
      end
      complete = cap_legal && (&seen_nx);
   end

   // Frame FSM: a completion while a frame is still pending is dropped unless it is accepted this cycle.
   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      seen_d    = seen_nx;
      overrun_d = overrun_q;
      case (state_q)
         ST_COLLECT: begin
            if (complete) begin
               frame_d = digit_d;
               seen_d  = '0;
               state_d = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (complete) begin
               seen_d = '0;
               if (frame_ready) frame_d   = digit_d;
               else             overrun_d = 1'b1;
            end else if (frame_ready) begin
               state_d = ST_COLLECT;
            end
         end
         default: state_d = ST_COLLECT;
      endcase
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_COLLECT;
         samp_q    <= '0;
         cnt_q     <= '0;
         seen_q    <= '0;
         digit_q   <= '0;
         frame_q   <= '0;
         bad_q     <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         samp_q    <= samp_d;
         cnt_q     <= cnt_d;
         seen_q    <= seen_d;
         digit_q   <= digit_d;
         frame_q   <= frame_d;
         bad_q     <= bad_d;
         overrun_q <= overrun_d;
      end
   end

   assign frame_data  = frame_q;
   assign frame_valid = (state_q == ST_PENDING);
   assign bad_pat     = bad_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans digits onto the bus and checks
// frames, bad-pattern pulses, overrun and reset behaviour against hand values.
`timescale 1ns/1ps
module tb_seg_scan_decoder;

   logic        clk;
   logic        rst;
   logic [6:0]  seg_in;
   logic [3:0]  an_in;
   logic [15:0] frame_data;
   logic        frame_valid;
   logic        frame_ready;
   logic        bad_pat;
   logic        overrun;

   int n_checks = 0;
   int n_err    = 0;
   int hs_cnt   = 0;
   int bad_cyc  = 0;
   logic [15:0] hs_data = '0;

   localparam logic [6:0] PAT [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

   seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg_in      (seg_in),
      .an_in       (an_in),
      .frame_data  (frame_data),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .bad_pat     (bad_pat),
      .overrun     (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observe handshakes and bad_pat pulse length mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (frame_valid && frame_ready) begin
            hs_cnt  = hs_cnt + 1;
            hs_data = frame_data;
         end
         if (bad_pat) bad_cyc = bad_cyc + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
      an_in  = an;
      seg_in = seg;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic show(input int d, input int v, input int n);
      hold(4'(1 << d), PAT[v], n);
   endtask

   task automatic idle(input int n);
      hold(4'b0000, 7'b0000000, n);
   endtask

   task automatic async_reset();
      #3 rst = 1'b1;
      #1;
      chk("rst_frame_data", 32'(frame_data), 32'h0);
      chk("rst_frame_valid", 32'(frame_valid), 32'h0);
      chk("rst_overrun", 32'(overrun), 32'h0);
      chk("rst_bad_pat", 32'(bad_pat), 32'h0);
      an_in  = '0;
      seg_in = '0;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      an_in       = '0;
      seg_in      = '0;
      frame_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_frame_data", 32'(frame_data), 32'h0);
      chk("reset_frame_valid", 32'(frame_valid), 32'h0);
      chk("reset_bad_pat", 32'(bad_pat), 32'h0);
      chk("reset_overrun", 32'(overrun), 32'h0);
      rst = 1'b0;
      idle(2);

      // basic scan 1,2,3,4 with consumer always ready
      frame_ready = 1'b1;
      show(0, 1, 6); show(1, 2, 6); show(2, 3, 6); show(3, 4, 6);
      idle(3);
      chk("basic_hs_count", 32'(hs_cnt), 32'd1);
      chk("basic_frame", 32'(hs_data), 32'h4321);
      chk("basic_valid_low", 32'(frame_valid), 32'h0);
      chk("basic_bad", 32'(bad_cyc), 32'd0);
      chk("basic_overrun", 32'(overrun), 32'h0);

      // glitch: 3-cycle hold must not capture digit0
      hold(4'b0001, PAT[1], 3);
      idle(2);
      show(1, 5, 6); show(2, 6, 6); show(3, 7, 6);
      idle(2);
      chk("glitch_no_frame", 32'(hs_cnt), 32'd1);
      show(0, 1, 5);
      idle(3);
      chk("hold5_hs_count", 32'(hs_cnt), 32'd2);
      chk("hold5_frame", 32'(hs_data), 32'h7651);

      // illegal pattern on digit2, blank, non-one-hot select
      hold(4'b0100, 7'b0000001, 6);
      idle(2);
      chk("illegal_bad_one_cycle", 32'(bad_cyc), 32'd1);
      show(0, 0, 6); show(1, 5, 6); show(3, 14, 6);
      idle(2);
      chk("illegal_seen2_clear", 32'(hs_cnt), 32'd2);
      hold(4'b0100, 7'b0000000, 6);
      idle(2);
      chk("blank_no_bad", 32'(bad_cyc), 32'd1);
      chk("blank_no_frame", 32'(hs_cnt), 32'd2);
      hold(4'b0110, PAT[8], 6);
      idle(2);
      chk("multi_an_no_capture", 32'(hs_cnt), 32'd2);
      show(2, 9, 6);
      idle(3);
      chk("illegal_then_frame_hs", 32'(hs_cnt), 32'd3);
      chk("illegal_then_frame", 32'(hs_data), 32'hE950);

      // overrun: consumer stalled over two frames
      frame_ready = 1'b0;
      show(0, 10, 6); show(1, 11, 6); show(2, 12, 6);
      hold(4'b1000, PAT[13], 4);
      chk("fv_before_capture", 32'(frame_valid), 32'h0);
      hold(4'b1000, PAT[13], 1);
      chk("fv_after_capture", 32'(frame_valid), 32'h1);
      chk("frame_a", 32'(frame_data), 32'hDCBA);
      hold(4'b1000, PAT[13], 1);
      idle(2);
      show(0, 15, 6); show(1, 14, 6); show(2, 0, 6); show(3, 8, 6);
      idle(2);
      chk("overrun_data_held", 32'(frame_data), 32'hDCBA);
      chk("overrun_set", 32'(overrun), 32'h1);
      chk("overrun_valid", 32'(frame_valid), 32'h1);
      chk("overrun_no_hs", 32'(hs_cnt), 32'd3);
      frame_ready = 1'b1;
      @(posedge clk);
      #1 frame_ready = 1'b0;
      chk("overrun_accept_hs", 32'(hs_cnt), 32'd4);
      chk("overrun_accept_data", 32'(hs_data), 32'hDCBA);
      chk("overrun_valid_low", 32'(frame_valid), 32'h0);
      idle(1);
      async_reset();
      idle(2);

      // accept in the same cycle the next frame completes
      show(0, 1, 6); show(1, 2, 6); show(2, 3, 6); show(3, 4, 6);
      idle(2);
      chk("b2b_first_valid", 32'(frame_valid), 32'h1);
      chk("b2b_first_data", 32'(frame_data), 32'h4321);
      show(0, 5, 6); show(1, 6, 6); show(2, 7, 6);
      hold(4'b1000, PAT[8], 4);
      frame_ready = 1'b1;
      hold(4'b1000, PAT[8], 1);
      frame_ready = 1'b0;
      chk("b2b_valid_stays", 32'(frame_valid), 32'h1);
      chk("b2b_new_data", 32'(frame_data), 32'h8765);
      chk("b2b_no_overrun", 32'(overrun), 32'h0);
      chk("b2b_hs_old", 32'(hs_data), 32'h4321);
      idle(2);
      frame_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("b2b_accept_new", 32'(hs_data), 32'h8765);
      chk("b2b_hs_count", 32'(hs_cnt), 32'd6);
      chk("b2b_valid_low", 32'(frame_valid), 32'h0);

      // reset mid-scan after two captures; no stale digits afterwards
      show(0, 10, 6); show(1, 11, 6);
      hold(4'b0100, PAT[12], 2);
      async_reset();
      idle(2);
      show(2, 5, 6); show(3, 6, 6);
      idle(2);
      chk("post_rst_no_stale_seen", 32'(hs_cnt), 32'd6);
      show(0, 7, 6); show(1, 8, 6);
      idle(3);
      chk("post_rst_hs", 32'(hs_cnt), 32'd7);
      chk("post_rst_frame", 32'(hs_data), 32'h6587);
      chk("post_rst_bad_total", 32'(bad_cyc), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
